ram_boot_arbiter: RTL and testbench
===================================

RAM_BOOT_ARBITER -- requirements
Module: ram_boot_arbiter

Interface
REQ-001 SHALL have parameter RELEASE_CYCLES, default 16: cycles CPU reset is held after load completes (1..255).
REQ-002 SHALL have parameter LOAD_TIMEOUT, default 1048576: max cycles in LOAD before abort (1..2^24-1).
REQ-003 SHALL have ports (name, direction, width, meaning):
- clk  in  1  sole clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- boot_req  in  1  pulse that starts a boot sequence.
- start_load  out  1  start strobe to the program loader.
- ld_addr  in  32  loader byte address.
- ld_data  in  32  loader data, big-endian, left-justified.
- ld_be  in  4  loader byte enables; nonzero means a write this cycle.
- ld_done  in  1  loader-finished level.
- cpu_rst  out  1  CPU reset.
- cpu_req  in  1  CPU access request.
- cpu_we  in  1  CPU write.
- cpu_addr  in  32  CPU byte address.
- cpu_wdata  in  32  CPU write data.
- cpu_be  in  4  CPU byte enables.
- cpu_ack  out  1  CPU access complete.
- cpu_rdata  out  32  CPU read data.
- ram_en  out  1  RAM port enable.
- ram_we  out  1  RAM write.
- ram_addr  out  30  RAM word address.
- ram_wdata  out  32  RAM write data.
- ram_be  out  4  RAM byte enables.
- ram_rdata  in  32  RAM read data, valid the cycle after ram_en with ram_we=0.
- ld_count  out  16  loader words written, saturating.
- load_err  out  1  sticky boot error flag.
- state  out  2  current state encoding.

Function
REQ-004 SHALL implement FSM IDLE=0, LOAD=1, HOLD=2, RUN=3.
REQ-005 IDLE->LOAD SHALL occur on the cycle after boot_req=1 is sampled; boot_req SHALL be ignored in every other state.
REQ-006 start_load SHALL be 1 in LOAD and HOLD and 0 in IDLE and RUN (registered, following state).
REQ-007 In LOAD, a cycle with ld_be!=0 and ld_addr[1:0]==0 SHALL drive ram_en=1, ram_we=1, ram_addr=ld_addr[31:2], ram_wdata=ld_data, ram_be=ld_be in the same cycle (combinational pass-through) and increment ld_count, saturating at 16'hFFFF.
REQ-008 In LOAD, ld_be!=0 with ld_addr[1:0]!=0 SHALL NOT write RAM and SHALL set load_err.
REQ-009 LOAD->HOLD SHALL occur the cycle after ld_done=1 is sampled; a write presented in that same cycle SHALL still be performed.
REQ-010 A 24-bit timeout counter SHALL clear on LOAD entry; on reaching LOAD_TIMEOUT-1 without ld_done, SHALL set load_err and go to HOLD.
REQ-011 HOLD SHALL count RELEASE_CYCLES cycles with an 8-bit counter cleared on entry, then go to RUN; ram_en=0 throughout HOLD.
REQ-012 cpu_rst SHALL be 1 in IDLE, LOAD and HOLD and 0 only in RUN; the first RUN cycle SHALL show cpu_rst=0.
REQ-013 RUN SHALL be absorbing until rst.
REQ-014 In RUN the CPU SHALL own the port: when cpu_req=1 and no access is pending, drive ram_en=1, ram_we=cpu_we, ram_addr=cpu_addr[31:2], ram_wdata=cpu_wdata, ram_be=cpu_be, and set pending.
REQ-015 cpu_ack SHALL pulse 1 for one cycle, the cycle after acceptance; for reads, cpu_rdata SHALL equal ram_rdata in that cycle.
REQ-016 While pending or acking, a new request SHALL NOT be accepted; max throughput SHALL be one access per 2 cycles; the CPU holds cpu_req until cpu_ack.
REQ-017 cpu_req outside RUN SHALL be ignored with no ack; loader inputs outside LOAD SHALL be ignored.
REQ-018 When no owner drives the port, ram_en=0, ram_we=0, ram_be=0, ram_addr=0, ram_wdata=0.

Reset
REQ-019 rst=1 SHALL force, on the next edge: state=IDLE, start_load=0, cpu_rst=1, cpu_ack=0, cpu_rdata=0, pending=0, ld_count=0, load_err=0, all counters 0.
REQ-020 rst mid-LOAD or mid-access SHALL abort without any further RAM write; the pending ack SHALL be dropped.

Verification
REQ-021 Bench SHALL check: rst, boot_req pulse, loader writes 0x0/DEADBEEF/1111 and 0x4/AB000000/1000, then ld_done -> ram writes word 0 and word 1 with matching be; ld_count=2; cpu_rst falls exactly RELEASE_CYCLES+1 cycles after ld_done is sampled.
REQ-022 Bench SHALL check: write at ld_addr=0x6 -> no RAM write, load_err=1, boot still completes to RUN.
REQ-023 Bench SHALL check: no ld_done with LOAD_TIMEOUT=32 -> load_err=1 and HOLD entered 32 cycles after LOAD entry.
REQ-024 Bench SHALL check: in RUN, CPU write 0x10=12345678 then read 0x10 -> acks one cycle after each acceptance, rdata=12345678, with the second request accepted no earlier than 2 cycles after the first.
REQ-025 Bench SHALL check: rst asserted during LOAD -> state=0, cpu_rst=1, ram_en=0, ld_count=0 next cycle; boot_req during RUN -> no state change.

Source files
------------

// File: rtl/ram_boot_arbiter.sv
// Boot-time RAM port arbiter: the program loader owns the RAM during LOAD, and the CPU
// owns it in RUN once its reset has been held for RELEASE_CYCLES.
module ram_boot_arbiter #(
    parameter int unsigned RELEASE_CYCLES = 16,
    parameter int unsigned LOAD_TIMEOUT   = 1048576
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        boot_req,
    output logic        start_load,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data,
    input  logic [3:0]  ld_be,
    input  logic        ld_done,
    output logic        cpu_rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_be,
    output logic        cpu_ack,
    output logic [31:0] cpu_rdata,
    output logic        ram_en,
    output logic        ram_we,
    output logic [29:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic [3:0]  ram_be,
    input  logic [31:0] ram_rdata,
    output logic [15:0] ld_count,
    output logic        load_err,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2,
        RUN  = 2'd3
    } state_t;

    localparam logic [23:0] TIMEOUT_LAST = 24'(LOAD_TIMEOUT - 1);
    localparam logic [7:0]  HOLD_LAST    = 8'(RELEASE_CYCLES - 1);

    state_t      cur, nxt;
    logic [23:0] tcnt;
    logic [7:0]  hcnt;
    logic        pending;
    logic        ld_wr, ld_bad, cpu_acc, timed_out;
    logic        unused_cpu_addr_lsbs;

    assign unused_cpu_addr_lsbs = ^cpu_addr[1:0];

    always_comb begin
        ld_wr     = (cur == LOAD) && (ld_be != '0) && (ld_addr[1:0] == 2'b00);
        ld_bad    = (cur == LOAD) && (ld_be != '0) && (ld_addr[1:0] != 2'b00);
        timed_out = (cur == LOAD) && !ld_done && (tcnt == TIMEOUT_LAST);
        cpu_acc   = (cur == RUN) && cpu_req && !pending;

        nxt = cur;
        case (cur)
            IDLE: if (boot_req) nxt = LOAD;
            LOAD: if (ld_done || timed_out) nxt = HOLD;
            HOLD: if (hcnt == HOLD_LAST) nxt = RUN;
            RUN:  nxt = RUN;
            default: nxt = IDLE;
        endcase
    end

    // Port mux is gated by rst so an abort cannot sneak a write through in the reset cycle.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        ram_be    = '0;
        if (!rst) begin
            if (ld_wr) begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = ld_addr[31:2];
                ram_wdata = ld_data;
                ram_be    = ld_be;
            end else if (cpu_acc) begin
                ram_en    = 1'b1;
                ram_we    = cpu_we;
                ram_addr  = cpu_addr[31:2];
                ram_wdata = cpu_wdata;
                ram_be    = cpu_be;
            end
        end
    end

    assign cpu_ack   = pending;
    assign cpu_rdata = pending ? ram_rdata : '0;
    assign state     = cur;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur        <= IDLE;
            start_load <= 1'b0;
            cpu_rst    <= 1'b1;
            pending    <= 1'b0;
            ld_count   <= '0;
            load_err   <= 1'b0;
            tcnt       <= '0;
            hcnt       <= '0;
        end else begin
            cur        <= nxt;
            start_load <= (nxt == LOAD) || (nxt == HOLD);
            cpu_rst    <= (nxt != RUN);
            pending    <= cpu_acc;
            tcnt       <= (cur == LOAD) ? tcnt + 24'd1 : '0;
            hcnt       <= (cur == HOLD) ? hcnt + 8'd1 : '0;
            if (ld_wr && (ld_count != '1))
                ld_count <= ld_count + 16'd1;
            if (ld_bad || timed_out)
                load_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ram_boot_arbiter.sv
// Directed bench for ram_boot_arbiter: vector table for the boot sequence, then
// hand-written CPU access, misaligned load, timeout and reset-abort sequences.
module tb_ram_boot_arbiter;

    localparam int unsigned REL = 4;
    localparam int unsigned TMO = 32;

    logic        clk = 1'b0;
    logic        rst, boot_req, start_load, ld_done, cpu_rst;
    logic [31:0] ld_addr, ld_data, cpu_addr, cpu_wdata, cpu_rdata, ram_wdata, ram_rdata;
    logic [3:0]  ld_be, cpu_be, ram_be;
    logic        cpu_req, cpu_we, cpu_ack, ram_en, ram_we, load_err;
    logic [29:0] ram_addr;
    logic [15:0] ld_count;
    logic [1:0]  state;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int acc_cyc;

    logic [31:0] mem [256];

    ram_boot_arbiter #(.RELEASE_CYCLES(REL), .LOAD_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .boot_req(boot_req), .start_load(start_load),
        .ld_addr(ld_addr), .ld_data(ld_data), .ld_be(ld_be), .ld_done(ld_done),
        .cpu_rst(cpu_rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_be(cpu_be), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_be(ram_be), .ram_rdata(ram_rdata), .ld_count(ld_count), .load_err(load_err),
        .state(state)
    );

    always #5 clk = ~clk;

    // Byte-enabled synchronous RAM; read data appears the cycle after the request.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_en) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++)
                    if (ram_be[b]) mem[ram_addr[7:0]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
            end else begin
                ram_rdata <= mem[ram_addr[7:0]];
            end
        end
    end

    typedef struct {
        logic        rst, boot;
        logic [31:0] addr, data;
        logic [3:0]  be;
        logic        done;
        logic [1:0]  st;
        logic        sl, crst, en, we;
        logic [29:0] ra;
        logic [31:0] rwd;
        logic [3:0]  rbe;
        logic [15:0] cnt;
        logic        err;
    } vec_t;

    function automatic vec_t mk(logic r, logic bt, logic [31:0] a, logic [31:0] d, logic [3:0] be,
                                logic dn, logic [1:0] st, logic sl, logic crst, logic en, logic we,
                                logic [29:0] ra, logic [31:0] rwd, logic [3:0] rbe,
                                logic [15:0] cnt, logic err);
        vec_t v;
        v.rst = r; v.boot = bt; v.addr = a; v.data = d; v.be = be; v.done = dn;
        v.st = st; v.sl = sl; v.crst = crst; v.en = en; v.we = we;
        v.ra = ra; v.rwd = rwd; v.rbe = rbe; v.cnt = cnt; v.err = err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        boot_req = 0; ld_addr = '0; ld_data = '0; ld_be = '0; ld_done = 0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0; cpu_be = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        step();
        rst = 0;
    endtask

    // One CPU access: acceptance cycle, then the ack cycle with cpu_req still held.
    task automatic cpu_access(input string name, input logic we, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] exp_rd);
        cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = wd; cpu_be = 4'hF;
        @(negedge clk);
        acc_cyc = cyc;
        chk({name, ".en"}, 32'(ram_en), 32'd1);
        chk({name, ".we"}, 32'(ram_we), 32'(we));
        chk({name, ".addr"}, 32'(ram_addr), 32'(a[31:2]));
        chk({name, ".ack0"}, 32'(cpu_ack), 32'd0);
        step();
        @(negedge clk);
        chk({name, ".ack"}, 32'(cpu_ack), 32'd1);
        chk({name, ".busy_en"}, 32'(ram_en), 32'd0);
        if (!we) chk({name, ".rdata"}, cpu_rdata, exp_rd);
        step();
        cpu_req = 0;
    endtask

    vec_t vecs [11];

    initial begin
        int n, prev_acc;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        ram_rdata = '0;
        clear_inputs();
        rst = 1;
        repeat (2) step();

        vecs[0]  = mk(0,0,32'h0,32'h0,4'h0,0, 0,0,1,0,0, 30'h0,32'h0,4'h0, 16'd0,0);
        vecs[1]  = mk(0,1,32'h0,32'h0,4'h0,0, 0,0,1,0,0, 30'h0,32'h0,4'h0, 16'd0,0);
        vecs[2]  = mk(0,0,32'h0,32'hDEADBEEF,4'hF,0, 1,1,1,1,1, 30'h0,32'hDEADBEEF,4'hF, 16'd0,0);
        vecs[3]  = mk(0,0,32'h4,32'hAB000000,4'h8,1, 1,1,1,1,1, 30'h1,32'hAB000000,4'h8, 16'd1,0);
        vecs[4]  = mk(0,0,32'h0,32'h0,4'h0,0, 2,1,1,0,0, 30'h0,32'h0,4'h0, 16'd2,0);
        vecs[5]  = mk(0,0,32'h8,32'h55555555,4'hF,0, 2,1,1,0,0, 30'h0,32'h0,4'h0, 16'd2,0);
        vecs[6]  = mk(0,0,32'h0,32'h0,4'h0,0, 2,1,1,0,0, 30'h0,32'h0,4'h0, 16'd2,0);
        vecs[7]  = mk(0,0,32'h0,32'h0,4'h0,0, 2,1,1,0,0, 30'h0,32'h0,4'h0, 16'd2,0);
        vecs[8]  = mk(0,0,32'h0,32'h0,4'h0,0, 3,0,0,0,0, 30'h0,32'h0,4'h0, 16'd2,0);
        vecs[9]  = mk(0,1,32'h0,32'h0,4'h0,0, 3,0,0,0,0, 30'h0,32'h0,4'h0, 16'd2,0);
        vecs[10] = mk(0,0,32'hC,32'h77777777,4'hF,1, 3,0,0,0,0, 30'h0,32'h0,4'h0, 16'd2,0);

        // Boot: cpu_rst low in vector 8, i.e. RELEASE_CYCLES+1 after ld_done in vector 3.
        for (int i = 0; i < 11; i++) begin
            rst = vecs[i].rst; boot_req = vecs[i].boot; ld_addr = vecs[i].addr;
            ld_data = vecs[i].data; ld_be = vecs[i].be; ld_done = vecs[i].done;
            @(negedge clk);
            chk($sformatf("v%0d.state", i), 32'(state), 32'(vecs[i].st));
            chk($sformatf("v%0d.start_load", i), 32'(start_load), 32'(vecs[i].sl));
            chk($sformatf("v%0d.cpu_rst", i), 32'(cpu_rst), 32'(vecs[i].crst));
            chk($sformatf("v%0d.ram_en", i), 32'(ram_en), 32'(vecs[i].en));
            chk($sformatf("v%0d.ram_we", i), 32'(ram_we), 32'(vecs[i].we));
            chk($sformatf("v%0d.ram_addr", i), 32'(ram_addr), 32'(vecs[i].ra));
            chk($sformatf("v%0d.ram_wdata", i), ram_wdata, vecs[i].rwd);
            chk($sformatf("v%0d.ram_be", i), 32'(ram_be), 32'(vecs[i].rbe));
            chk($sformatf("v%0d.ld_count", i), 32'(ld_count), 32'(vecs[i].cnt));
            chk($sformatf("v%0d.load_err", i), 32'(load_err), 32'(vecs[i].err));
            chk($sformatf("v%0d.cpu_ack", i), 32'(cpu_ack), 32'd0);
            step();
        end
        clear_inputs();

        // CPU accesses in RUN, back to back.
        cpu_access("cpu_wr10", 1, 32'h10, 32'h12345678, 32'h0);
        prev_acc = acc_cyc;
        cpu_access("cpu_rd10", 0, 32'h10, 32'h0, 32'h12345678);
        chk("cpu_gap_ge2", 32'((acc_cyc - prev_acc) >= 2), 32'd1);
        cpu_access("cpu_rd04", 0, 32'h4, 32'h0, 32'hAB000000);
        cpu_access("cpu_rd00", 0, 32'h0, 32'h0, 32'hDEADBEEF);

        // Reset during an access cycle: no write, ack dropped.
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h20; cpu_wdata = 32'hCAFEF00D; cpu_be = 4'hF;
        rst = 1;
        @(negedge clk);
        chk("rst_acc.ram_en", 32'(ram_en), 32'd0);
        step();
        rst = 0; cpu_req = 0;
        @(negedge clk);
        chk("rst_acc.ack", 32'(cpu_ack), 32'd0);
        chk("rst_acc.state", 32'(state), 32'd0);
        chk("rst_acc.cpu_rst", 32'(cpu_rst), 32'd1);
        chk("rst_acc.mem", mem[8], 32'h0);
        chk("rst_acc.rdata", cpu_rdata, 32'h0);

        // Misaligned loader write.
        do_reset();
        boot_req = 1; step(); boot_req = 0;
        ld_addr = 32'h6; ld_data = 32'h99999999; ld_be = 4'hF;
        @(negedge clk);
        chk("mis.state", 32'(state), 32'd1);
        chk("mis.ram_en", 32'(ram_en), 32'd0);
        step();
        ld_be = '0; ld_done = 1;
        @(negedge clk);
        chk("mis.load_err", 32'(load_err), 32'd1);
        step();
        ld_done = 0;
        n = 0;
        while (state != 2'd3 && n < 50) begin step(); n++; end
        chk("mis.reached_run", 32'(state), 32'd3);
        chk("mis.err_sticky", 32'(load_err), 32'd1);
        chk("mis.ld_count", 32'(ld_count), 32'd0);

        // Load timeout.
        do_reset();
        boot_req = 1; step(); boot_req = 0;
        chk("tmo.entry", 32'(state), 32'd1);
        n = 0;
        while (state == 2'd1 && n < 100) begin step(); n++; end
        chk("tmo.cycles", 32'(n), 32'(TMO));
        chk("tmo.state", 32'(state), 32'd2);
        chk("tmo.load_err", 32'(load_err), 32'd1);

        // Reset in the middle of LOAD with a write presented.
        do_reset();
        boot_req = 1; step(); boot_req = 0;
        ld_addr = 32'h0; ld_data = 32'h01020304; ld_be = 4'hF;
        step();
        chk("rstld.count1", 32'(ld_count), 32'd1);
        ld_addr = 32'h8; rst = 1;
        @(negedge clk);
        chk("rstld.ram_en_rst", 32'(ram_en), 32'd0);
        step();
        rst = 0;
        @(negedge clk);
        chk("rstld.state", 32'(state), 32'd0);
        chk("rstld.cpu_rst", 32'(cpu_rst), 32'd1);
        chk("rstld.ram_en", 32'(ram_en), 32'd0);
        chk("rstld.ld_count", 32'(ld_count), 32'd0);
        chk("rstld.start_load", 32'(start_load), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
